// File: rtl/versatile_fifo_sync_multi_ch_if.sv
// rtl/versatile_fifo_sync_multi_ch_if.sv - write/read/flag bundle of the multi-channel FIFO
interface versatile_fifo_sync_multi_ch_if #(
  parameter int data_width = 18,
  parameter int ch_width   = 2
);
  logic [data_width-1:0]    d;
  logic                     wr;
  logic [ch_width-1:0]      wr_ch;
  logic                     rd;
  logic [ch_width-1:0]      rd_ch;
  logic [2**ch_width-1:0]   flush;
  logic [data_width-1:0]    q;
  logic                     q_valid;
  logic [2**ch_width-1:0]   fifo_full;
  logic [2**ch_width-1:0]   fifo_empty;
  logic [2**ch_width-1:0]   overflow;

  modport master (
    output d, wr, wr_ch, rd, rd_ch, flush,
    input  q, q_valid, fifo_full, fifo_empty, overflow
  );

  modport slave (
    input  d, wr, wr_ch, rd, rd_ch, flush,
    output q, q_valid, fifo_full, fifo_empty, overflow
  );
endinterface

// File: rtl/versatile_fifo_sync_multi_ch.sv
// rtl/versatile_fifo_sync_multi_ch.sv - single-clock multi-channel FIFO over one shared dual-port RAM
// Each channel owns RAM region {ch, ptr}; pointers carry one extra wrap bit for full/empty.
module versatile_fifo_sync_multi_ch #(
  parameter int data_width = 18,
  parameter int addr_width = 4,
  parameter int ch_width   = 2
) (
  input logic clk,
  input logic rst,
  versatile_fifo_sync_multi_ch_if.slave bus
);
  localparam int ch_n      = 2**ch_width;
  localparam int ram_depth = 2**(addr_width + ch_width);

  typedef logic [addr_width:0] ptr_t;

  ptr_t                            wptr [ch_n];
  ptr_t                            rptr [ch_n];
  logic [data_width-1:0]           ram  [ram_depth];
  logic [ch_n-1:0]                 full;
  logic [ch_n-1:0]                 empty;
  logic [ch_n-1:0]                 ovf;
  logic [data_width-1:0]           q_r;
  logic                            q_valid_r;
  logic                            wr_ok;
  logic                            wr_drop;
  logic                            rd_ok;
  logic [addr_width+ch_width-1:0]  wr_addr;
  logic [addr_width+ch_width-1:0]  rd_addr;

  always_comb begin
    full  = '0;
    empty = '0;
    for (int c = 0; c < ch_n; c++) begin
      empty[c] = (wptr[c] == rptr[c]);
      full[c]  = (wptr[c][addr_width-1:0] == rptr[c][addr_width-1:0]) &&
                 (wptr[c][addr_width] != rptr[c][addr_width]);
    end
  end

  // Flags are pre-cycle values, so a same-channel wr+rd never touches one RAM address twice.
  assign wr_ok   = bus.wr && !full[bus.wr_ch]  && !bus.flush[bus.wr_ch];
  assign wr_drop = bus.wr &&  full[bus.wr_ch]  && !bus.flush[bus.wr_ch];
  assign rd_ok   = bus.rd && !empty[bus.rd_ch] && !bus.flush[bus.rd_ch];
  assign wr_addr = {bus.wr_ch, wptr[bus.wr_ch][addr_width-1:0]};
  assign rd_addr = {bus.rd_ch, rptr[bus.rd_ch][addr_width-1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < ch_n; c++) begin
        wptr[c] <= '0;
        rptr[c] <= '0;
      end
      ovf <= '0;
    end else begin
      for (int c = 0; c < ch_n; c++) begin
        if (bus.flush[c]) begin
          wptr[c] <= '0;
          rptr[c] <= '0;
          ovf[c]  <= 1'b0;
        end else begin
          if (wr_ok && (bus.wr_ch == ch_width'(c)))
            wptr[c] <= wptr[c] + 1'b1;
          if (rd_ok && (bus.rd_ch == ch_width'(c)))
            rptr[c] <= rptr[c] + 1'b1;
          if (wr_drop && (bus.wr_ch == ch_width'(c)))
            ovf[c] <= 1'b1;
        end
      end
    end
  end

  // RAM is not reset; an empty channel can never expose stale words.
  always_ff @(posedge clk) begin
    if (!rst && wr_ok)
      ram[wr_addr] <= bus.d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_r       <= '0;
      q_valid_r <= 1'b0;
    end else begin
      q_valid_r <= rd_ok;
      if (rd_ok)
        q_r <= ram[rd_addr];
    end
  end

  assign bus.q          = q_r;
  assign bus.q_valid    = q_valid_r;
  assign bus.fifo_full  = full;
  assign bus.fifo_empty = empty;
  assign bus.overflow   = ovf;
endmodule

// File: tb/tb_versatile_fifo_sync_multi_ch.sv
// tb/tb_versatile_fifo_sync_multi_ch.sv - vector table plus queue-scoreboard bench for the multi-channel FIFO
module tb_versatile_fifo_sync_multi_ch;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  versatile_fifo_sync_multi_ch_if #(.data_width(18), .ch_width(2)) bus ();

  versatile_fifo_sync_multi_ch #(.data_width(18), .addr_width(4), .ch_width(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        wr;
    logic [1:0]  wr_ch;
    logic [17:0] d;
    logic        rd;
    logic [1:0]  rd_ch;
    logic [3:0]  flush;
    logic        qv;
    logic [17:0] q;
    logic [3:0]  full;
    logic [3:0]  empty;
    logic [3:0]  ovf;
  } vec_t;

  vec_t vecs[$];
  int n_checks = 0;
  int n_fail = 0;

  logic [17:0] mq [4][$];
  logic [3:0]  m_ovf;
  logic [17:0] m_q;

  function automatic vec_t mk(logic wr, logic [1:0] wch, logic [17:0] d, logic rd, logic [1:0] rch,
                              logic [3:0] fl, logic qv, logic [17:0] q, logic [3:0] full,
                              logic [3:0] empty, logic [3:0] ovf);
    vec_t v;
    v.wr = wr; v.wr_ch = wch; v.d = d; v.rd = rd; v.rd_ch = rch; v.flush = fl;
    v.qv = qv; v.q = q; v.full = full; v.empty = empty; v.ovf = ovf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input logic w, input logic [1:0] wch, input logic [17:0] dd,
                      input logic r, input logic [1:0] rch, input logic [3:0] fl);
    bus.wr = w; bus.wr_ch = wch; bus.d = dd;
    bus.rd = r; bus.rd_ch = rch; bus.flush = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic qv, input logic [17:0] q,
                         input logic [3:0] full, input logic [3:0] empty, input logic [3:0] ovf);
    chk({tag, " q_valid"}, 32'(bus.q_valid), 32'(qv));
    chk({tag, " q"}, 32'(bus.q), 32'(q));
    chk({tag, " fifo_full"}, 32'(bus.fifo_full), 32'(full));
    chk({tag, " fifo_empty"}, 32'(bus.fifo_empty), 32'(empty));
    chk({tag, " overflow"}, 32'(bus.overflow), 32'(ovf));
  endtask

  initial begin
    // Tests 1-4 as a directed table; expected values are the state just after each edge.
    for (int i = 0; i < 16; i++)
      vecs.push_back(mk(1, 1, 18'(i + 1), 0, 0, 0, 0, 0, (i == 15) ? 4'b0010 : 4'b0000, 4'b1101, 0));
    vecs.push_back(mk(1, 1, 18'h3FFFF, 0, 0, 0, 0, 0, 4'b0010, 4'b1101, 4'b0010));
    for (int i = 0; i < 16; i++)
      vecs.push_back(mk(0, 0, 0, 1, 1, 0, 1, 18'(i + 1), 0, (i == 15) ? 4'b1111 : 4'b1101, 4'b0010));
    vecs.push_back(mk(1, 1, 18'h00AAA, 1, 1, 0, 0, 18'h10, 0, 4'b1101, 4'b0010));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 1, 18'h00AAA, 0, 4'b1111, 4'b0010));
    for (int i = 0; i < 16; i++)
      vecs.push_back(mk(1, 0, 18'(32'h100 + i), 0, 0, 0, 0, 18'h00AAA,
                        (i == 15) ? 4'b0001 : 4'b0000, 4'b1110, 4'b0010));
    vecs.push_back(mk(1, 0, 18'h3FFFF, 1, 0, 0, 1, 18'h100, 0, 4'b1110, 4'b0011));
    vecs.push_back(mk(1, 0, 18'h3FFFE, 1, 0, 0, 1, 18'h101, 0, 4'b1110, 4'b0011));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 18'h101, 0, 4'b1110, 4'b0011));

    rst = 1'b1;
    tick(1, 1, 18'h1234, 1, 1, 4'hF);
    tick(1, 2, 18'h1234, 0, 0, 0);
    rst = 1'b0;
    chk_all("reset", 0, 0, 4'b0000, 4'b1111, 4'b0000);

    for (int i = 0; i < vecs.size(); i++) begin
      tick(vecs[i].wr, vecs[i].wr_ch, vecs[i].d, vecs[i].rd, vecs[i].rd_ch, vecs[i].flush);
      chk_all($sformatf("vec%0d", i), vecs[i].qv, vecs[i].q, vecs[i].full, vecs[i].empty, vecs[i].ovf);
    end

    // Test 5: flush ch2 (and ch0) while ch3 holds data untouched.
    for (int i = 0; i < 5; i++) tick(1, 2, 18'(32'h200 + i), 0, 0, 0);
    for (int i = 0; i < 3; i++) tick(1, 3, 18'(32'h300 + i), 0, 0, 0);
    chk_all("fill23", 0, 18'h101, 4'b0000, 4'b0010, 4'b0011);
    tick(1, 2, 18'h2FFFF, 1, 2, 4'b0101);
    chk_all("flush", 0, 18'h101, 4'b0000, 4'b0111, 4'b0010);
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 0, 1, 3, 0);
      chk_all($sformatf("ch3rd%0d", i), 1, 18'(32'h300 + i), 4'b0000,
              (i == 2) ? 4'b1111 : 4'b0111, 4'b0010);
    end
    tick(0, 0, 0, 1, 2, 0);
    chk_all("rd_flushed", 0, 18'h302, 4'b0000, 4'b1111, 4'b0010);

    // Test 6: random traffic against a queue scoreboard, with a reset mid-stream.
    rst = 1'b1;
    tick(0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) mq[c].delete();
    m_ovf = 0;
    m_q = 0;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      logic w, r, wok, rok, wdrop;
      logic [1:0] wc, rc;
      logic [17:0] dd;
      logic [3:0] fl, efull, eempty;
      int wb;
      wb = ((cyc / 150) % 2) ? 35 : 70;
      w  = ($urandom_range(0, 99) < wb);
      r  = ($urandom_range(0, 99) < (105 - wb));
      wc = 2'($urandom_range(0, 3));
      rc = 2'($urandom_range(0, 3));
      dd = 18'($urandom);
      fl = ($urandom_range(0, 99) == 0) ? 4'($urandom) : 4'b0000;
      if (cyc == 3000) begin
        rst = 1'b1;
        tick(1, wc, dd, 1, rc, fl);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) mq[c].delete();
        m_ovf = 0;
        m_q = 0;
        chk_all("midrst", 0, 0, 4'b0000, 4'b1111, 4'b0000);
        continue;
      end
      wok   = w && (mq[wc].size() < 16) && !fl[wc];
      wdrop = w && (mq[wc].size() == 16) && !fl[wc];
      rok   = r && (mq[rc].size() > 0) && !fl[rc];
      for (int c = 0; c < 4; c++)
        if (fl[c]) begin
          mq[c].delete();
          m_ovf[c] = 1'b0;
        end
      if (rok) m_q = mq[rc].pop_front();
      if (wok) mq[wc].push_back(dd);
      if (wdrop) m_ovf[wc] = 1'b1;
      for (int c = 0; c < 4; c++) begin
        efull[c]  = (mq[c].size() == 16);
        eempty[c] = (mq[c].size() == 0);
      end
      tick(w, wc, dd, r, rc, fl);
      chk_all($sformatf("rnd%0d", cyc), rok, m_q, efull, eempty, m_ovf);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
